// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu: single-outstanding load/store unit between execute and the data bus.
// Optional build macro MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into err (default: masked).
module ysyx_25030085_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              st_done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_e;

    function automatic logic funct3_ok(input logic wen, input logic [2:0] f3);
        if (wen) begin
            return f3 inside {3'b000, 3'b001, 3'b010};
        end
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Extract byte/half at the access offset and extend according to funct3[2].
    function automatic logic [DATA_W-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [DATA_W-1:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [DATA_W-1:0]  r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{(DATA_W-8){b[7]}}, b};
            3'b100:  r = {{(DATA_W-8){1'b0}}, b};
            3'b001:  r = {{(DATA_W-16){h[15]}}, h};
            3'b101:  r = {{(DATA_W-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [1:0] sz, input logic [DATA_W-1:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              misalign;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        wen_d         = wen_q;
        f3_d          = f3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        illegal_d     = illegal_q;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wstrb     = 4'b0000;
        mem_wdata     = '0;
        wb_valid      = 1'b0;
        st_done       = 1'b0;
        err           = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wen_d     = req_wen;
                    f3_d      = req_funct3;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    rd_d      = req_rd;
                    illegal_d = !funct3_ok(req_wen, req_funct3) || misalign;
                    // Illegal accesses never touch the bus; report straight from DONE.
                    state_d   = illegal_d ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wen       = wen_q;
                if (wen_q) begin
                    mem_wstrb = store_strb(f3_q[1:0], addr_q[1:0]);
                    mem_wdata = store_data(f3_q[1:0], wdata_q);
                end
                if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    // Write-back registers only move on a real pulse, so they hold otherwise.
                    if (!wen_q && (rd_q != 5'd0)) begin
                        wb_data_d = load_fmt(f3_q, addr_q[1:0], mem_rdata);
                        wb_rd_d   = rd_q;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                err      = illegal_q;
                wb_valid = !illegal_q && !wen_q && (rd_q != 5'd0);
                st_done  = !illegal_q && wen_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wb_data_q <= '0;
            wb_rd_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    // Request latches are qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        wen_q     <= wen_d;
        f3_q      <= f3_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        rd_q      <= rd_d;
        illegal_q <= illegal_d;
    end

    assign wb_data = wb_data_q;
    assign wb_rd   = wb_rd_q;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Self-checking bench for ysyx_25030085_lsu: directed accesses against a byte-level behavioural model.
module tb_ysyx_25030085_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid, st_done, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic        e_req_ready = 1'b1, e_mreq_valid = 1'b0, e_mwen = 1'b0;
    logic [31:0] e_maddr = '0, e_mwdata = '0, e_wb_data = '0;
    logic [3:0]  e_mwstrb = '0;
    logic        e_wb_valid = 1'b0, e_st_done = 1'b0, e_err = 1'b0;
    logic [4:0]  e_wb_rd = '0;

    always #5 clk = ~clk;

    ysyx_25030085_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_legal(input logic wen, input logic [2:0] f3, input logic [31:0] addr);
        int   size;
        logic ok;
        logic trap;
        size = m_size(f3);
        ok   = (size != 0) && !(wen && f3[2]);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = 1'b1;
`endif
        if (ok && trap && ((int'(addr[1:0]) % size) != 0)) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        int     size;
        int     base;
        longint v;
        size = m_size(f3);
        base = int'(addr[1:0]);
        base = base - (base % size);
        v    = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(word[8*(base+i) +: 8]) << (8*i));
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1))) v = v - (longint'(1) << (8*size));
        return v[31:0];
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                           output logic [3:0] strb, output logic [31:0] data);
        int size;
        int base;
        size = m_size(f3);
        base = int'(addr[1:0]);
        base = base - (base % size);
        strb = '0;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            data[8*i +: 8] = rs2[8*(i % size) +: 8];
            if (i >= base && i < base + size) strb[i] = 1'b1;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_req_ready));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mreq_valid));
            if (e_mreq_valid) begin
                chk("mem_addr", mem_addr, e_maddr);
                chk("mem_wen", 32'(mem_wen), 32'(e_mwen));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_mwstrb));
                if (e_mwen) chk("mem_wdata", mem_wdata, e_mwdata);
            end
            chk("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
            chk("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
            chk("wb_data", wb_data, e_wb_data);
            chk("st_done", 32'(st_done), 32'(e_st_done));
            chk("err", 32'(err), 32'(e_err));
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic access(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                          input int rdy_dly, input int rsp_dly);
        logic       legal;
        logic [3:0] s;
        logic [31:0] d;
        legal = m_legal(wen, f3, addr);
        s = '0;
        d = '0;
        if (legal && wen) m_store(f3, addr, wdata, s, d);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        e_req_ready = 1'b0;
        if (!legal) begin
            e_err = 1'b1;
            @(posedge clk); #1;
            e_err = 1'b0;
        end else begin
            e_mreq_valid = 1'b1; e_maddr = {addr[31:2], 2'b00}; e_mwen = wen;
            e_mwstrb = s; e_mwdata = d;
            mem_req_ready = 1'b0;
            for (int i = 0; i < rdy_dly; i++) begin
                req_valid = 1'b1;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            e_mreq_valid = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                @(posedge clk); #1;
            end
            mem_rdata = rdata; mem_rsp_valid = 1'b1;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            if (wen) begin
                e_st_done = 1'b1;
            end else if (rd != 5'd0) begin
                e_wb_valid = 1'b1; e_wb_rd = rd; e_wb_data = m_load(f3, addr, rdata);
            end
            @(posedge clk); #1;
            e_st_done = 1'b0; e_wb_valid = 1'b0;
        end
        e_req_ready = 1'b1;
    endtask

    initial begin
        logic [3:0]  ps;
        logic [31:0] pd;
        rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

        // Reset state
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk_en = 1'b1;
        @(negedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Model pins
        chk("model_lb", m_load(3'b000, 32'h8000_0003, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("model_lhu", m_load(3'b101, 32'h8000_0102, 32'h9ABC_5678), 32'h0000_9ABC);
        m_store(3'b000, 32'h8000_0201, 32'h1122_33AA, ps, pd);
        chk("model_sb_strb", 32'(ps), 32'h2);
        chk("model_sb_data", pd, 32'hAAAA_AAAA);

        // Loads
        access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0);
        chk("lb_wb_data_lit", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd_lit", 32'(wb_rd), 32'd7);
        access(1'b0, 3'b101, 32'h8000_0102, 32'h0, 5'd12, 32'h9ABC_5678, 0, 0);
        chk("lhu_wb_data_lit", wb_data, 32'h0000_9ABC);
        chk("lhu_wb_rd_lit", 32'(wb_rd), 32'd12);
        access(1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd3, 32'h8001_7FFF, 2, 1);
        access(1'b0, 3'b001, 32'h0000_1000, 32'h0, 5'd4, 32'h8001_7FFF, 0, 0);
        access(1'b0, 3'b100, 32'h0000_1006, 32'h0, 5'd31, 32'hDEF0_1234, 0, 2);
        access(1'b0, 3'b000, 32'h0000_1001, 32'h0, 5'd9, 32'h0000_7F00, 0, 0);
        access(1'b0, 3'b010, 32'h1234_5678, 32'h0, 5'd1, 32'hCAFE_BABE, 1, 0);

        // Stores
        access(1'b1, 3'b000, 32'h8000_0201, 32'h1122_33AA, 5'd0, 32'h0, 0, 0);
        access(1'b1, 3'b001, 32'h8000_0202, 32'h5566_BEEF, 5'd0, 32'h0, 0, 1);
        access(1'b1, 3'b001, 32'h8000_0200, 32'h5566_BEEF, 5'd0, 32'h0, 0, 0);
        access(1'b1, 3'b010, 32'h8000_0300, 32'hA5A5_0F0F, 5'd0, 32'h0, 3, 2);
        access(1'b1, 3'b000, 32'h8000_0303, 32'h0000_0042, 5'd0, 32'h0, 0, 0);

        // Illegal funct3
        access(1'b0, 3'b011, 32'h0000_2000, 32'h0, 5'd5, 32'h0, 0, 0);
        access(1'b0, 3'b110, 32'h0000_2000, 32'h0, 5'd5, 32'h0, 0, 0);
        access(1'b0, 3'b111, 32'h0000_2000, 32'h0, 5'd5, 32'h0, 0, 0);
        access(1'b1, 3'b011, 32'h0000_2000, 32'h0, 5'd0, 32'h0, 0, 0);
        access(1'b1, 3'b100, 32'h0000_2000, 32'h0, 5'd0, 32'h0, 0, 0);

        // Load to x0: bus access, no write-back, wb_data/wb_rd hold
        access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd0, 32'h1111_2222, 0, 0);

        // Misaligned (masked in the default build, trapped with MISALIGN_TRAP_EN)
        access(1'b0, 3'b010, 32'h0000_4002, 32'h0, 5'd6, 32'h0102_0304, 0, 0);
        access(1'b0, 3'b001, 32'h0000_4001, 32'h0, 5'd8, 32'hFFFF_8765, 0, 0);
        access(1'b1, 3'b001, 32'h0000_4003, 32'h0000_9876, 5'd0, 32'h0, 0, 0);
        access(1'b1, 3'b010, 32'h0000_4001, 32'h0BAD_F00D, 5'd0, 32'h0, 0, 0);

        // Asynchronous reset while waiting for the response
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_5000; req_rd = 5'd10;
        @(posedge clk); #1;
        req_valid = 1'b0; e_req_ready = 1'b0;
        e_mreq_valid = 1'b1; e_maddr = 32'h0000_5000; e_mwen = 1'b0; e_mwstrb = 4'b0000;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0; e_mreq_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        e_req_ready = 1'b1; e_wb_data = '0; e_wb_rd = '0;
        @(negedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        repeat (2) @(posedge clk);
        #1; mem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Recovery after reset
        access(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd11, 32'h0F1E_2D3C, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
